// File: rtl/button_pkg.sv
// Shared constants for the iceFUN push-button front end.
// Cycle counts are derived from the 12 MHz board clock.
package button_pkg;

  localparam int ICEFUN_NUM_BUTTONS = 4;
  localparam int CLK_HZ             = 12_000_000;
  localparam int DEBOUNCE_MS        = 10;
  localparam int HOLD_MS            = 1000;

  // Converts a duration in milliseconds to clock cycles of the board clock.
  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  localparam int DEBOUNCE_CYCLES_DEFAULT = ms_to_cycles(DEBOUNCE_MS);
  localparam int HOLD_CYCLES_DEFAULT     = ms_to_cycles(HOLD_MS);

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw (pressed = 1) levels in, debounced levels and event
// pulses out. master = debouncer side, slave = pin/user side.
interface button_debounce_if #(
  parameter int N = 4
);
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_state;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_long;

  modport master (
    input  btn_raw,
    output btn_state,
    output btn_press,
    output btn_release,
    output btn_long
  );

  modport slave (
    output btn_raw,
    input  btn_state,
    input  btn_press,
    input  btn_release,
    input  btn_long
  );
endinterface

// File: rtl/debounce_bit.sv
// One debounce channel: 2-flop synchronizer, persistence counter,
// registered press/release pulses and, with LONG_PRESS_EN defined,
// a saturating hold counter producing a single long-press pulse.
// Input bus.btn_raw is already in the "pressed = 1" view.
module debounce_bit
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input logic               clock,
  input logic               reset_n,
  button_debounce_if.master bus
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Both counts must be at least one cycle for the compare values to exist.
  if (DEBOUNCE_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_param_check
    $error("debounce_bit: DEBOUNCE_CYCLES and HOLD_CYCLES must be >= 1");
  end

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  // Next-state: synchronizer shift, persistence count, edge pulses.
  always_comb begin
    s1_d    = bus.btn_raw[0];
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (s2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      state_d = s2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d   = state_d & ~state_q;
    release_d = ~state_d & state_q;
  end

  // Channel registers; reset leaves the synchronizer at "not pressed".
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign bus.btn_state   = state_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

`ifdef LONG_PRESS_EN
  // The counter saturates at HOLD_CYCLES, so the value HOLD_CYCLES-1 is
  // seen for exactly one cycle per press; the registered pulse follows it.
  localparam int             HW        = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0]  HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          long_q, long_d;

  // Hold count advances only while the debounced level is pressed.
  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!state_q) begin
      hold_d = '0;
    end else begin
      if (hold_q != HOLD_MAX) hold_d = hold_q + HW'(1);
      long_d = (hold_q == HOLD_LAST);
    end
  end

  // Hold counter and long-press pulse registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign bus.btn_long = long_q;
`else
  assign bus.btn_long = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// iceFUN push-button front end: polarity correction plus one debounce
// channel per button. Optional long-press detection is built when the
// LONG_PRESS_EN macro is defined; otherwise btn_long is held at 0.
module button_debounce
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = ICEFUN_NUM_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_state,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_long
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    button_debounce_if #(.N(1)) ch_if ();

    // Internal view is always pressed = 1.
    assign ch_if.btn_raw   = btn_raw[i] ^ ACTIVE_LOW;
    assign btn_state[i]    = ch_if.btn_state[0];
    assign btn_press[i]    = ch_if.btn_press[0];
    assign btn_release[i]  = ch_if.btn_release[0];
    assign btn_long[i]     = ch_if.btn_long[0];

    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES)
    ) u_bit (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (ch_if.master)
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random button activity,
// all checked every cycle against a window-based reference model.
module tb_button_debounce;
  localparam int NB   = 4;
  localparam int DEB  = 8;
  localparam int HOLD = 32;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  button_debounce_if #(.N(NB)) bus ();

  button_debounce #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DEB),
    .ACTIVE_LOW      (1'b1),
    .HOLD_CYCLES     (HOLD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .btn_raw     (bus.btn_raw),
    .btn_state   (bus.btn_state),
    .btn_press   (bus.btn_press),
    .btn_release (bus.btn_release),
    .btn_long    (bus.btn_long)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: a channel's level flips once the last DEB synchronized
  // samples all disagree with it. Samples reach the counter two edges late.
  bit hist[NB][$];
  bit m_state[NB];
  int rise_edge[NB];
  int edge_n = 0;
  logic [NB-1:0] e_state, e_press, e_rel, e_long;

  int n_press[NB];
  int n_rel[NB];
  int n_long[NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      hist[c].delete();
      for (int j = 0; j < DEB + 2; j++) hist[c].push_back(1'b0);
      m_state[c]   = 1'b0;
      rise_edge[c] = 0;
    end
    e_state = '0;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] lvl;
    lvl = ~bus.btn_raw;
    edge_n++;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    if (!reset_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < NB; c++) begin
      bit held;
      int sz;
      held = 1'b1;
      sz = hist[c].size();
      for (int j = 2; j <= DEB + 1; j++)
        if (hist[c][sz - j] == m_state[c]) held = 1'b0;
`ifdef LONG_PRESS_EN
      if (m_state[c] && (edge_n - rise_edge[c] == HOLD)) e_long[c] = 1'b1;
`endif
      if (held) begin
        m_state[c] = !m_state[c];
        if (m_state[c]) begin
          e_press[c]   = 1'b1;
          rise_edge[c] = edge_n;
        end else begin
          e_rel[c] = 1'b1;
        end
      end
      e_state[c] = m_state[c];
      hist[c].push_back(lvl[c]);
      void'(hist[c].pop_front());
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NB; c++) begin
      n_press[c] = 0;
      n_rel[c]   = 0;
      n_long[c]  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("state",   32'(bus.btn_state),   32'(e_state));
    check("press",   32'(bus.btn_press),   32'(e_press));
    check("release", 32'(bus.btn_release), 32'(e_rel));
    check("long",    32'(bus.btn_long),    32'(e_long));
    check("excl",    32'(bus.btn_press & bus.btn_release), 32'd0);
    for (int c = 0; c < NB; c++) begin
      n_press[c] += int'(bus.btn_press[c]);
      n_rel[c]   += int'(bus.btn_release[c]);
      n_long[c]  += int'(bus.btn_long[c]);
    end
  endtask

  // which: 0 state high, 1 press, 2 long, 3 release, other state low
  function automatic bit sig(input int which, input int ch);
    case (which)
      0:       return bus.btn_state[ch];
      1:       return bus.btn_press[ch];
      2:       return bus.btn_long[ch];
      3:       return bus.btn_release[ch];
      default: return !bus.btn_state[ch];
    endcase
  endfunction

  task automatic wait_for(input int which, input int ch, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!sig(which, ch) && n < limit);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.btn_raw = '1;
    reset_n = 1'b0;
    model_reset();
    clear_counts();

    // Reset with all buttons released.
    repeat (3) tick();
    check("rst_outs", 32'({bus.btn_state, bus.btn_press, bus.btn_release, bus.btn_long}), 32'd0);
    reset_n = 1'b1;
    repeat (50) tick();
    check("idle_pulses", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3]
                             + n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3]), 32'd0);

    // Clean press on channel 0.
    clear_counts();
    bus.btn_raw[0] = 1'b0;
    wait_for(0, 0, 40, n);
    check("clean_lat", 32'(n), 32'(DEB + 2));
    check("clean_press_now", 32'(bus.btn_press[0]), 32'd1);
    tick();
    check("clean_press_1cyc", 32'(bus.btn_press[0]), 32'd0);
    check("clean_others", 32'(n_press[1] + n_press[2] + n_press[3]), 32'd0);
    bus.btn_raw[0] = 1'b1;
    wait_for(3, 0, 40, n);
    check("clean_rel_seen", 32'(bus.btn_release[0]), 32'd1);
    repeat (5) tick();

    // Bounce on channel 1: toggles every 3 cycles, final level pressed.
    clear_counts();
    for (int i = 0; i < 13; i++) begin
      bus.btn_raw[1] = ~bus.btn_raw[1];
      if (i < 12) repeat (3) tick();
    end
    wait_for(1, 1, 40, n);
    check("bounce_lat", 32'(n), 32'(DEB + 2));
    repeat (5) tick();
    check("bounce_presses", 32'(n_press[1]), 32'd1);
    check("bounce_releases", 32'(n_rel[1]), 32'd0);
    bus.btn_raw[1] = 1'b1;
    wait_for(3, 1, 40, n);
    repeat (5) tick();

    // Threshold: DEB-1 cycle pulse rejected, DEB cycle pulse accepted.
    clear_counts();
    bus.btn_raw[2] = 1'b0;
    repeat (DEB - 1) tick();
    bus.btn_raw[2] = 1'b1;
    repeat (20) tick();
    check("thr_short_press", 32'(n_press[2]), 32'd0);
    bus.btn_raw[2] = 1'b0;
    repeat (DEB) tick();
    bus.btn_raw[2] = 1'b1;
    repeat (20) tick();
    check("thr_exact_press", 32'(n_press[2]), 32'd1);
    check("thr_exact_rel", 32'(n_rel[2]), 32'd1);

    // All four pressed on the same edge.
    clear_counts();
    bus.btn_raw = '0;
    wait_for(1, 0, 40, n);
    check("sim_press", 32'(bus.btn_press), 32'hF);
    bus.btn_raw = '1;
    wait_for(3, 0, 40, n);
    check("sim_release", 32'(bus.btn_release), 32'hF);
    repeat (5) tick();

    // Reset while channel 0 is pressed and channel 2 is mid-count, then
    // channel 2 held through reset.
    bus.btn_raw[0] = 1'b0;
    wait_for(1, 0, 40, n);
    bus.btn_raw[2] = 1'b0;
    repeat (3) tick();
    clear_counts();
    reset_n = 1'b0;
    repeat (3) tick();
    check("rst_mid_state", 32'(bus.btn_state), 32'd0);
    bus.btn_raw[0] = 1'b1;
    reset_n = 1'b1;
    wait_for(1, 2, 40, n);
    check("rst_held_lat", 32'(n), 32'(DEB + 2));
    check("rst_no_pulse_ch0", 32'(n_press[0] + n_rel[0]), 32'd0);
    bus.btn_raw[2] = 1'b1;
    wait_for(3, 2, 40, n);
    repeat (5) tick();

    // Long press on channel 3, held 100 cycles.
    clear_counts();
    bus.btn_raw[3] = 1'b0;
    wait_for(0, 3, 40, n);
    wait_for(2, 3, 60, n);
`ifdef LONG_PRESS_EN
    check("long_lat", 32'(n), 32'(HOLD));
`else
    check("long_absent", 32'(n), 32'd60);
`endif
    repeat (100 - DEB - 2 - n) tick();
    bus.btn_raw[3] = 1'b1;
    wait_for(3, 3, 40, n);
    repeat (5) tick();
`ifdef LONG_PRESS_EN
    check("long_count", 32'(n_long[3]), 32'd1);
`else
    check("long_count", 32'(n_long[3]), 32'd0);
`endif

    // Short hold on channel 3: no long pulse.
    clear_counts();
    bus.btn_raw[3] = 1'b0;
    repeat (20) tick();
    bus.btn_raw[3] = 1'b1;
    repeat (20) tick();
    check("short_press", 32'(n_press[3]), 32'd1);
    check("short_no_long", 32'(n_long[3]), 32'd0);

    // Random activity, including occasional resets.
    for (int it = 0; it < 250; it++) begin
      bus.btn_raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) begin
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
      end
      repeat ($urandom_range(1, 14)) tick();
    end
    bus.btn_raw = '0;
    repeat (60) tick();
    bus.btn_raw = '1;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
